// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks A,B,C,D through 0..15, samples F1/F2 after a settle time,
// and packs the results into two 16-bit tables. Optional compare logic: SCAN_COMPARE_EN.
module truth_table_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        F1,
    input  logic        F2,
    output logic        busy,
    output logic        done,
    output logic [15:0] f1_table,
    output logic [15:0] f2_table
`ifdef SCAN_COMPARE_EN
    ,
    input  logic [15:0] exp_f1,
    input  logic [15:0] exp_f2,
    output logic        mismatch,
    output logic [3:0]  mism_idx
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;

`ifdef SCAN_COMPARE_EN
    // The last table bit is written on the same edge the comparison is taken,
    // so the comparison uses the tables with F1/F2 merged into bit 15.
    logic [15:0] f1_final;
    logic [15:0] f2_final;
    logic [15:0] diff;
    logic [3:0]  first_idx;

    always_comb begin
        f1_final     = f1_table;
        f2_final     = f2_table;
        f1_final[15] = F1;
        f2_final[15] = F2;
        diff         = (f1_final ^ exp_f1) | (f2_final ^ exp_f2);
        first_idx    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) first_idx = 4'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 4'd0;
            cnt      <= 4'd0;
            {A, B, C, D} <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            f1_table <= 16'd0;
            f2_table <= 16'd0;
`ifdef SCAN_COMPARE_EN
            mismatch <= 1'b0;
            mism_idx <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    {A, B, C, D} <= 4'd0;
                    if (start) begin
                        f1_table <= 16'd0;
                        f2_table <= 16'd0;
                        idx      <= 4'd0;
                        cnt      <= SETTLE_INIT;
                        busy     <= 1'b1;
                        state    <= SETTLE;
`ifdef SCAN_COMPARE_EN
                        mismatch <= 1'b0;
                        mism_idx <= 4'd0;
`endif
                    end
                end
                SETTLE: begin
                    {A, B, C, D} <= idx;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= SAMPLE;
                end
                SAMPLE: begin
                    f1_table[idx] <= F1;
                    f2_table[idx] <= F2;
                    if (idx == 4'd15) begin
                        {A, B, C, D} <= 4'd0;
                        done  <= 1'b1;
                        state <= FINISH;
`ifdef SCAN_COMPARE_EN
                        mismatch <= |diff;
                        mism_idx <= first_idx;
`endif
                    end else begin
                        idx   <= idx + 4'd1;
                        {A, B, C, D} <= idx + 4'd1;
                        cnt   <= SETTLE_INIT;
                        state <= SETTLE;
                    end
                end
                FINISH: begin
                    {A, B, C, D} <= 4'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential harness stage that drives the 4-input combinational decode block. On a start request it walks the block's A, B, C, D inputs through all 16 combinations. After a programmable settle time it samples the block's F1 and F2 outputs. It assembles the samples into two 16-bit truth-table words for readback by the control/debug logic.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles each input vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; sampled only in IDLE.
- A, B, C, D  out  1 each  registered drive to decode block; {A,B,C,D} = current index, A is MSB.
- F1, F2  in  1 each  decode block outputs.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; tables are valid.
- f1_table  out  16  bit i = F1 sampled with {A,B,C,D}=i.
- f2_table  out  16  bit i = F2 sampled with {A,B,C,D}=i.
- Only with SCAN_COMPARE_EN: exp_f1, exp_f2 in 16; mismatch out 1; mism_idx out 4.

## Operation
- Reset values:
  - state=IDLE; A=B=C=D=0; busy=0; done=0.
  - f1_table=f2_table=0; mismatch=0; mism_idx=0.
- IDLE:
  - Drives 0000.
  - start=1 → clear both tables, idx=0, cnt=SETTLE_CYCLES, go SETTLE.
- SETTLE:
  - Drives idx; cnt decrements each cycle.
  - Leaves for SAMPLE after exactly SETTLE_CYCLES cycles in the state.
- SAMPLE (1 cycle):
  - Writes F1→f1_table[idx] and F2→f2_table[idx].
  - If idx==15 → FINISH.
  - Otherwise idx+1, cnt reload, → SETTLE.
  - Drive changes to the new idx on the same edge.
- FINISH (1 cycle):
  - done=1, busy=0 on exit.
  - Drive returns to 0000; → IDLE.
- start while not in IDLE is ignored; no queueing.
- start held high continuously → back-to-back scans, each re-accepted from IDLE.
- Tables hold their values until the next accepted start; they are undefined (partial) while busy.
- Index never wraps inside a scan; idx 15 terminates.
- rst_n low at any point, mid-scan included: immediate return to reset values; the partial table is discarded.

## Timing
- Start accepted on edge E0.
- Vector i is driven from edge E0+i*(SETTLE_CYCLES+1) and sampled at edge E0+(i+1)*(SETTLE_CYCLES+1).
- done is high for the cycle following edge E0+16*(SETTLE_CYCLES+1). With default 1, done follows edge E0+32.
- busy rises after E0 and falls together with done deasserting.
- F1/F2 are sampled raw; the decode block must settle within SETTLE_CYCLES cycles of combinational delay.

## Configuration
- SCAN_COMPARE_EN defined:
  - Adds the exp_f1, exp_f2, mismatch and mism_idx ports.
  - On the FINISH edge: mismatch = |((f1_table^exp_f1)|(f2_table^exp_f2)).
  - mism_idx = lowest failing index, or 0 if no mismatch.
  - Both hold until the next FINISH; both are cleared at start acceptance.
- SCAN_COMPARE_EN undefined: those ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle, scanner wired to the decode block:
  - All outputs are 0.
  - A..D stay 0000 for 20 cycles with start=0.
- SETTLE_CYCLES=1, start pulse:
  - done exactly 32 cycles after the accepting edge.
  - f1_table=0xFF5E, f2_table=0xAAFA.
  - Vectors observed on A..D are 0..15 in order.
- start pulsed at cycle 10 of a scan:
  - Ignored; done occurs once with the same tables.
  - A second start after done produces identical tables.
- rst_n asserted at vector 7:
  - Outputs are 0 asynchronously.
  - A new scan after release completes normally with the same tables.
- SETTLE_CYCLES=3:
  - Each vector held 3 cycles, sampled on the 4th.
  - done 64 cycles after accept.
- SCAN_COMPARE_EN, exp_f1=0xFF5E, exp_f2=0xAAFA → mismatch=0.
- SCAN_COMPARE_EN, exp_f2=0xAAFB → mismatch=1, mism_idx=0.
